// File: rtl/iz_param_pkg.sv
// Shared definitions for the Izhikevich parameter serializer and its loader.
// Frame layout constants, serializer state encoding and default neuron parameters.
package iz_param_pkg;

  localparam int unsigned PARAM_W    = 16;
  localparam int unsigned NUM_PARAMS = 4;
  localparam int unsigned GAP_CYCLES = 2;
  localparam int unsigned FRAME_W    = PARAM_W * NUM_PARAMS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    SHIFT    = 2'd2,
    GAP      = 2'd3
  } ser_state_e;

  // Default Izhikevich parameters in Q8.8 fixed point.
  localparam logic signed [PARAM_W-1:0] IZ_DEFAULT_A = 16'sd51;
  localparam logic signed [PARAM_W-1:0] IZ_DEFAULT_B = 16'sd51;
  localparam logic signed [PARAM_W-1:0] IZ_DEFAULT_C = -16'sd16640;
  localparam logic signed [PARAM_W-1:0] IZ_DEFAULT_D = 16'sd512;

  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic [PARAM_W-1:0] a,
    input logic [PARAM_W-1:0] b,
    input logic [PARAM_W-1:0] c,
    input logic [PARAM_W-1:0] d
  );
    return {a, b, c, d};
  endfunction

endpackage

// File: rtl/iz_param_serializer.sv
// Serializes four signed parameters MSB-first behind a one-cycle preamble strobe.
// Optional trailing even-parity bit selected by macro IZ_PARAM_SER_PARITY_EN.
module iz_param_serializer
  import iz_param_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      start,
  input  logic signed [PARAM_W-1:0] param_a,
  input  logic signed [PARAM_W-1:0] param_b,
  input  logic signed [PARAM_W-1:0] param_c,
  input  logic signed [PARAM_W-1:0] param_d,
  output logic                      serial_data_out,
  output logic                      load_enable_out,
  output logic                      busy,
  output logic                      done
);

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_PREAMBLE = PREAMBLE;
  localparam logic [1:0] ST_SHIFT    = SHIFT;
  localparam logic [1:0] ST_GAP      = GAP;

  localparam logic [5:0] CNT_LAST = 6'd63;
  localparam logic [1:0] GAP_LAST = 2'(GAP_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [1:0]         gap_q, gap_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic               sdo_q, sdo_d;
  logic               le_q, le_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef IZ_PARAM_SER_PARITY_EN
  logic               par_q, par_d;
  logic               par_sent_q, par_sent_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sr_d    = sr_q;
    sdo_d   = sdo_q;
    le_d    = le_q;
    done_d  = 1'b0;
`ifdef IZ_PARAM_SER_PARITY_EN
    par_d      = par_q;
    par_sent_d = par_sent_q;
`endif
    case (state_q)
      ST_IDLE: begin
        sdo_d = 1'b0;
        le_d  = 1'b0;
        if (start) begin
          sr_d    = pack_frame(param_a, param_b, param_c, param_d);
          state_d = ST_PREAMBLE;
          le_d    = 1'b1;
          cnt_d   = '0;
`ifdef IZ_PARAM_SER_PARITY_EN
          par_sent_d = 1'b0;
`endif
        end
      end
      ST_PREAMBLE: begin
        // First data bit leaves on the edge that ends the preamble.
        state_d = ST_SHIFT;
        sdo_d   = sr_q[FRAME_W-1];
        sr_d    = {sr_q[FRAME_W-2:0], 1'b0};
        cnt_d   = '0;
`ifdef IZ_PARAM_SER_PARITY_EN
        par_d = sr_q[FRAME_W-1];
`endif
      end
      ST_SHIFT: begin
        if (cnt_q != CNT_LAST) begin
          sdo_d = sr_q[FRAME_W-1];
          sr_d  = {sr_q[FRAME_W-2:0], 1'b0};
          cnt_d = cnt_q + 6'd1;
`ifdef IZ_PARAM_SER_PARITY_EN
          par_d = par_q ^ sr_q[FRAME_W-1];
`endif
        end else begin
`ifdef IZ_PARAM_SER_PARITY_EN
          if (!par_sent_q) begin
            sdo_d      = par_q;
            par_sent_d = 1'b1;
          end else begin
            state_d = ST_GAP;
            le_d    = 1'b0;
            sdo_d   = 1'b0;
            gap_d   = '0;
            cnt_d   = '0;
          end
`else
          state_d = ST_GAP;
          le_d    = 1'b0;
          sdo_d   = 1'b0;
          gap_d   = '0;
          cnt_d   = '0;
`endif
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        le_d    = 1'b0;
        sdo_d   = 1'b0;
        cnt_d   = '0;
        gap_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      sr_q    <= '0;
      sdo_q   <= 1'b0;
      le_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef IZ_PARAM_SER_PARITY_EN
      par_q      <= 1'b0;
      par_sent_q <= 1'b0;
`endif
    end else if (enable) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sr_q    <= sr_d;
      sdo_q   <= sdo_d;
      le_q    <= le_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef IZ_PARAM_SER_PARITY_EN
      par_q      <= par_d;
      par_sent_q <= par_sent_d;
`endif
    end
  end

  assign serial_data_out = sdo_q;
  assign load_enable_out = le_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_iz_param_serializer.sv
// Scoreboard bench for iz_param_serializer: a stream monitor acting as the loader
// reassembles each frame and checks it against the values queued at start.
module tb_iz_param_serializer;
  import iz_param_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic start = 1'b0;
  logic signed [15:0] param_a = '0;
  logic signed [15:0] param_b = '0;
  logic signed [15:0] param_c = '0;
  logic signed [15:0] param_d = '0;
  logic serial_data_out, load_enable_out, busy, done;

`ifdef IZ_PARAM_SER_PARITY_EN
  localparam int StrobeLen = 66;
`else
  localparam int StrobeLen = 65;
`endif

  int errors = 0;
  int checks = 0;
  int sent = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  iz_param_serializer dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .start           (start),
    .param_a         (param_a),
    .param_b         (param_b),
    .param_c         (param_c),
    .param_d         (param_d),
    .serial_data_out (serial_data_out),
    .load_enable_out (load_enable_out),
    .busy            (busy),
    .done            (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Loader model: samples one bit per enabled cycle while the strobe is high.
  logic mon_bits[0:69];
  int   le_cnt = 0;
  int   low_cnt = 0;
  int   frames_seen = 0;
  int   done_cnt = 0;
  bit   in_frame = 1'b0;

  always @(negedge clk) begin
    logic [63:0] w;
    logic [63:0] e;
    if (!reset) begin
      in_frame = 1'b0;
      le_cnt   = 0;
    end else if (enable) begin
      if (done) done_cnt++;
      if (load_enable_out) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          le_cnt   = 0;
          if (frames_seen > 0) check("inter-frame low gap>=2", 64'(low_cnt >= 2), 64'd1);
        end
        if (le_cnt == 0) check("preamble data bit", 64'(serial_data_out), 64'd0);
        else if (le_cnt <= 70) mon_bits[le_cnt-1] = serial_data_out;
        le_cnt++;
        low_cnt = 0;
      end else begin
        low_cnt++;
        if (in_frame) begin
          in_frame = 1'b0;
          frames_seen++;
          for (int i = 0; i < 64; i++) w[63-i] = mon_bits[i];
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected frame: got 0x%0h, required none", w);
          end else begin
            e = exp_q.pop_front();
            check("param_a", 64'(w[63:48]), 64'(e[63:48]));
            check("param_b", 64'(w[47:32]), 64'(e[47:32]));
            check("param_c", 64'(w[31:16]), 64'(e[31:16]));
            check("param_d", 64'(w[15:0]), 64'(e[15:0]));
            check("strobe length", 64'(le_cnt), 64'(StrobeLen));
`ifdef IZ_PARAM_SER_PARITY_EN
            check("parity bit", 64'(mon_bits[64]), 64'(^e));
`endif
          end
        end
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    param_a = a;
    param_b = b;
    param_c = c;
    param_d = d;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back({a, b, c, d});
    sent++;
    check("busy after accept", 64'(busy), 64'd1);
    check("strobe after accept", 64'(load_enable_out), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy=1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [15:0] d);
    wait_idle();
    @(posedge clk);
    #1;
    issue(a, b, c, d);
  endtask

  initial begin
    int n;
    #3 reset = 1'b0;
    #1;
    check("reset serial_data_out", 64'(serial_data_out), 64'd0);
    check("reset load_enable_out", 64'(load_enable_out), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle busy after release", 64'(busy), 64'd0);
    check("idle strobe after release", 64'(load_enable_out), 64'd0);

    // Defaults: bits 1-16 = 0x0033, bits 49-64 = 0x0200.
    send(IZ_DEFAULT_A, IZ_DEFAULT_B, IZ_DEFAULT_C, IZ_DEFAULT_D);
    send(16'h1234, 16'hFFFE, 16'hBF00, 16'h7FFF);

    // Enable stall of 5 cycles around bit 20.
    send(16'hA5A5, 16'h0F0F, 16'h8001, 16'h7FFE);
    repeat (20) @(posedge clk);
    #1 enable = 1'b0;
    repeat (5) @(posedge clk);
    #1 enable = 1'b1;

    // Re-pulse start with new params at bit 10; original values must arrive.
    send(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    repeat (10) @(posedge clk);
    #1;
    param_a = 16'hFFFF;
    param_b = 16'hEEEE;
    param_c = 16'hDDDD;
    param_d = 16'hCCCC;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    // Reset abort around bit 40.
    send(16'h5555, 16'hAAAA, 16'h0001, 16'h8000);
    repeat (40) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("abort strobe", 64'(load_enable_out), 64'd0);
    check("abort data", 64'(serial_data_out), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    void'(exp_q.pop_back());
    sent--;
    @(posedge clk);
    #1 reset = 1'b1;

    // Complete frame after abort, then a back-to-back start during done.
    send(16'h0001, 16'h8000, 16'h00FF, 16'hFF00);
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done seen before back-to-back", 64'(done), 64'd1);
    issue(16'h7FFF, 16'h8000, 16'hC3C3, 16'h3C3C);

`ifdef IZ_PARAM_SER_PARITY_EN
    send(16'h0000, 16'h0000, 16'h0000, 16'h0001);
`endif

    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    check("frames delivered", 64'(frames_seen), 64'(sent));
    check("done pulses", 64'(done_cnt), 64'(sent));
    check("scoreboard empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
